mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates a fetch port and a load/store port onto a
// single 8-bit RAM interface, assembling little-endian words on reads and splitting them
// on writes.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_idx_q, last_idx_d;   // index of the final byte (N-1)
  logic        last_ls_q, last_ls_d;     // 1: LS was granted last, 0: IF
  logic        is_ls_q, is_ls_d;         // current transaction belongs to LS
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        io_addr;
  logic        if_elig, ls_elig;
  logic        grant_ls, grant_if;
  logic [1:0]  nxt_cnt;
  logic [31:0] rd_word;
  logic [31:0] wr_shift;

  // Map access size to the index of its last byte; size 3 behaves as a word.
  function automatic logic [1:0] size_last(input logic [1:0] sz);
    case (sz)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Eligibility, arbitration and datapath helpers.
  always_comb begin
    io_addr  = (ls_addr == 32'h0003_0000) || (ls_addr == 32'h0003_0004);
    // A port whose done is high is finishing; its held request must not be re-accepted.
    if_elig  = if_req && !if_done_q;
    ls_elig  = ls_req && !ls_done_q && !(ls_wr && io_addr && io_buffer_full);
    grant_ls = ls_elig && (!if_elig || !last_ls_q);
    grant_if = if_elig && !grant_ls;
    nxt_cnt  = cnt_q + 2'd1;
    // Bytes above the current index are still zero, giving zero-extension for free.
    rd_word  = rbuf_q | ({24'b0, mem_din} << {cnt_q, 3'b000});
    wr_shift = wdata_q >> {nxt_cnt, 3'b000};
  end

  // Next-state and output register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    last_ls_d  = last_ls_q;
    is_ls_d    = is_ls_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;

    if (rdy_in) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!clear && (grant_ls || grant_if)) begin
            last_ls_d = grant_ls;
            is_ls_d   = grant_ls;
            cnt_d     = 2'd0;
            rbuf_d    = 32'b0;
            if (grant_ls) begin
              mem_a_d    = ls_addr;
              last_idx_d = size_last(ls_size);
              wdata_d    = ls_wdata;
              if (ls_wr) begin
                state_d    = StWr;
                mem_dout_d = ls_wdata[7:0];
                mem_wr_d   = 1'b1;
              end else begin
                state_d = StRd;
              end
            end else begin
              mem_a_d    = if_addr;
              last_idx_d = 2'd3;
              state_d    = StRd;
            end
          end
        end
        StRd: begin
          if (clear) begin
            state_d = StIdle;
          end else if (cnt_q == last_idx_q) begin
            state_d = StIdle;
            if (is_ls_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = rd_word;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rd_word;
            end
          end else begin
            rbuf_d  = rd_word;
            cnt_d   = nxt_cnt;
            mem_a_d = mem_a_q + 32'd1;
          end
        end
        StWr: begin
          // Stores ignore clear: once bytes reach memory the access must finish.
          if (cnt_q == last_idx_q) begin
            state_d   = StIdle;
            mem_wr_d  = 1'b0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d      = nxt_cnt;
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = wr_shift[7:0];
          end
        end
        default: begin
          state_d  = StIdle;
          mem_wr_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      last_idx_q <= 2'd0;
      last_ls_q  <= 1'b0;
      is_ls_q    <= 1'b0;
      wdata_q    <= 32'b0;
      rbuf_q     <= 32'b0;
      mem_a_q    <= 32'b0;
      mem_dout_q <= 8'b0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'b0;
      ls_rdata_q <= 32'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      last_ls_q  <= last_ls_d;
      is_ls_q    <= is_ls_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_dout = mem_dout_q;
  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 1 KiB asynchronous-read RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic        io_buffer_full;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram [1024];
  logic       ram_loaded = 1'b0;

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_wr          (ls_wr),
    .ls_size        (ls_size),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  always #5 clk = ~clk;

  // RAM byte for the address presented in the current cycle.
  assign mem_din = ram[mem_a[9:0]];

  // Preload on the first edge, then commit writes.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h11;
      ram[10'h101] <= 8'h22;
      ram[10'h102] <= 8'h33;
      ram[10'h103] <= 8'h44;
      ram[10'h3fe] <= 8'h5a;
      ram[10'h3ff] <= 8'h6b;
      ram_loaded   <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
    repeat (3) tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_ls_done", 32'(ls_done), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b1;

    // IF word read from 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("if_mem_a", mem_a, 32'h100 + 32'(k));
      chk("if_mem_wr", 32'(mem_wr), 32'h0);
      chk("if_done_early", 32'(if_done), 32'h0);
    end
    tick();
    chk("if_done", 32'(if_done), 32'h1);
    chk("if_data", if_data, 32'h4433_2211);
    if_req = 1'b0;
    tick();
    chk("if_done_pulse", 32'(if_done), 32'h0);
    chk("if_data_hold", if_data, 32'h4433_2211);

    // LS word store 0xAABBCCDD to 0x200
    w = 32'hAABB_CCDD;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h200; ls_wdata = w;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_mem_a", mem_a, 32'h200 + 32'(k));
      chk("st_mem_dout", 32'(mem_dout), 32'(w[8*k +: 8]));
      chk("st_mem_wr", 32'(mem_wr), 32'h1);
      chk("st_done_early", 32'(ls_done), 32'h0);
    end
    tick();
    chk("st_wr_end", 32'(mem_wr), 32'h0);
    chk("st_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();
    chk("st_done_pulse", 32'(ls_done), 32'h0);

    // Half load from 0x202, then byte load from 0x101
    ls_req = 1'b1; ls_size = 2'd1; ls_addr = 32'h202;
    tick(); chk("ldh_a0", mem_a, 32'h202);
    tick(); chk("ldh_a1", mem_a, 32'h203); chk("ldh_early", 32'(ls_done), 32'h0);
    tick(); chk("ldh_done", 32'(ls_done), 32'h1); chk("ldh_data", ls_rdata, 32'h0000_AABB);
    ls_req = 1'b0;
    tick();
    ls_req = 1'b1; ls_size = 2'd0; ls_addr = 32'h101;
    tick(); chk("ldb_a0", mem_a, 32'h101);
    tick(); chk("ldb_done", 32'(ls_done), 32'h1); chk("ldb_data", ls_rdata, 32'h0000_0022);
    ls_req = 1'b0;
    tick();

    // Arbitration from reset: LS, IF, LS
    rst_in = 1'b0;
    tick();
    chk("arb_rst_rdata", ls_rdata, 32'h0);
    rst_in = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    tick(); chk("arb_ls_first", mem_a, 32'h200);
    repeat (3) tick();
    tick();
    chk("arb_ls_done", 32'(ls_done), 32'h1);
    chk("arb_ls_data", ls_rdata, 32'hAABB_CCDD);
    chk("arb_if_wait", 32'(if_done), 32'h0);
    tick(); chk("arb_if_next", mem_a, 32'h100); chk("arb_ls_pulse", 32'(ls_done), 32'h0);
    repeat (3) tick();
    tick(); chk("arb_if_done", 32'(if_done), 32'h1);
    if_req = 1'b0;
    tick(); chk("arb_ls_again", mem_a, 32'h200);
    repeat (3) tick();
    tick(); chk("arb_ls2_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0;
    tick();
    // Last grant was LS, so IF wins a tie
    if_req = 1'b1; ls_req = 1'b1;
    tick(); chk("arb_tie_if", mem_a, 32'h100);
    repeat (3) tick();
    tick(); chk("arb_tie_if_done", 32'(if_done), 32'h1);
    if_req = 1'b0;
    tick(); chk("arb_tie_ls", mem_a, 32'h200);
    repeat (3) tick();
    tick(); chk("arb_tie_ls_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0;
    tick();

    // Byte store to the UART address blocked while buffer is full
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000;
    ls_wdata = 32'hFFFF_FF41; io_buffer_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("io_blocked_wr", 32'(mem_wr), 32'h0);
      chk("io_blocked_done", 32'(ls_done), 32'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr", 32'(mem_wr), 32'h1);
    chk("io_a", mem_a, 32'h0003_0000);
    chk("io_dout", 32'(mem_dout), 32'h41);
    tick();
    chk("io_wr_end", 32'(mem_wr), 32'h0);
    chk("io_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();

    // Clear aborts an IF read
    if_req = 1'b1; if_addr = 32'h100;
    tick(); chk("clr_if_a0", mem_a, 32'h100);
    tick(); chk("clr_if_a1", mem_a, 32'h101);
    clear = 1'b1; if_req = 1'b0;
    tick(); chk("clr_if_done", 32'(if_done), 32'h0); chk("clr_if_wr", 32'(mem_wr), 32'h0);
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_if_no_done", 32'(if_done), 32'h0);
    end
    chk("clr_if_data_hold", if_data, 32'h4433_2211);

    // Clear does not abort a store; clear in idle blocks a grant
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h210; ls_wdata = 32'h1122_3344;
    tick(); chk("clr_st_a0", mem_a, 32'h210);
    tick(); chk("clr_st_a1", mem_a, 32'h211);
    clear = 1'b1;
    tick(); chk("clr_st_a2", mem_a, 32'h212); chk("clr_st_wr", 32'(mem_wr), 32'h1);
    chk("clr_st_dout", 32'(mem_dout), 32'h22);
    tick(); chk("clr_st_a3", mem_a, 32'h213); chk("clr_st_dout3", 32'(mem_dout), 32'h11);
    tick(); chk("clr_st_done", 32'(ls_done), 32'h1); chk("clr_st_wr_end", 32'(mem_wr), 32'h0);
    ls_req = 1'b0; ls_wr = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    tick(); chk("clr_idle_no_grant", mem_a, 32'h213);
    clear = 1'b0;
    tick(); chk("clr_after_grant", mem_a, 32'h200);
    repeat (3) tick();
    tick(); chk("clr_after_done", 32'(if_done), 32'h1); chk("clr_after_data", if_data, 32'hAABB_CCDD);
    if_req = 1'b0;
    tick();

    // rdy_in low freezes the read and stretches the done pulse
    if_req = 1'b1; if_addr = 32'h100;
    tick(); chk("rdy_a0", mem_a, 32'h100);
    tick(); chk("rdy_a1", mem_a, 32'h101);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rdy_hold_a", mem_a, 32'h101);
    end
    rdy_in = 1'b1;
    tick(); chk("rdy_a2", mem_a, 32'h102);
    tick(); chk("rdy_a3", mem_a, 32'h103);
    tick(); chk("rdy_done", 32'(if_done), 32'h1); chk("rdy_data", if_data, 32'h4433_2211);
    rdy_in = 1'b0; if_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rdy_done_hold", 32'(if_done), 32'h1);
    end
    rdy_in = 1'b1;
    tick(); chk("rdy_done_expire", 32'(if_done), 32'h0);

    // Address wraps modulo 2^32
    if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
    tick(); chk("wrap_a0", mem_a, 32'hFFFF_FFFE);
    tick(); chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
    tick(); chk("wrap_a2", mem_a, 32'h0000_0000);
    tick(); chk("wrap_a3", mem_a, 32'h0000_0001);
    tick(); chk("wrap_done", 32'(if_done), 32'h1); chk("wrap_data", if_data, 32'h0041_6B5A);
    if_req = 1'b0;
    tick();

    // Reset mid-store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h220; ls_wdata = 32'h5566_7788;
    tick(); chk("rst_st_wr0", 32'(mem_wr), 32'h1);
    tick(); chk("rst_st_wr1", 32'(mem_wr), 32'h1);
    #2 rst_in = 1'b0;
    #1;
    chk("rst_async_wr", 32'(mem_wr), 32'h0);
    chk("rst_async_a", mem_a, 32'h0);
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_done", 32'(ls_done), 32'h0);
      chk("rst_no_wr", 32'(mem_wr), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
